mem_access: RTL and testbench

- Memory stage of the sequential Y86-64 processor. Sits directly downstream of execute and consumes its valE together with decode's valA and fetch's valP.
- Performs the data-memory read or write required by the current icode against a byte-wide data RAM, one byte per cycle. Produces valM and the processor status for writeback and PC update.
- A start/done handshake lets the top-level sequencer stall the next instruction until the access completes.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/data_mem_byte.sv | 25 ++
 rtl/mem_access.sv | 123 ++++++++++++
 tb/tb_mem_access.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, processor status values and the
// memory-stage FSM state type.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [1:0] SINS = 2'd0;
    localparam logic [1:0] SAOK = 2'd1;
    localparam logic [1:0] SHLT = 2'd2;
    localparam logic [1:0] SADR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } mem_state_t;

endpackage

// File: rtl/data_mem_byte.sv
// Byte-wide data RAM: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module data_mem_byte #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_access.sv
// Y86-64 sequential memory stage: moves one 8-byte quadword to or from the
// byte RAM, one byte per cycle, and reports valM and processor status.
module mem_access
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instruct_err,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        mem_err,
    output logic [1:0]  stat
);

    localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - 8);

    mem_state_t        state, state_nxt;
    logic [2:0]        cnt;
    logic              wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [63:0]       wdata_r;

    logic              accept, is_wr, is_rd, bad_ins, addr_bad, go_xfer;
    logic [63:0]       req_addr, req_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, ram_rdata;
    logic              ram_we;
    logic [5:0]        byte_lsb;

    // Request decode from the live inputs; only used on the accepting edge.
    always_comb begin
        is_wr     = (icode == RMMOVQ) || (icode == PUSHQ) || (icode == CALL);
        is_rd     = (icode == MRMOVQ) || (icode == RET) || (icode == POPQ);
        req_addr  = ((icode == RET) || (icode == POPQ)) ? valA : valE;
        req_wdata = (icode == CALL) ? valP : valA;
        bad_ins   = instruct_err || (icode > POPQ);
        // Full 64-bit compare so huge addresses fault instead of wrapping.
        addr_bad  = req_addr > LAST_BASE;
        go_xfer   = !bad_ins && (icode != HALT) && (is_wr || is_rd) && !addr_bad;
        accept    = (state == ST_IDLE) && start && (stat == SAOK);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = go_xfer ? ST_XFER : ST_DONE;
            ST_XFER: if (cnt == 3'd7) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 3'd0;
            wr_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 64'd0;
            valM    <= 64'd0;
            mem_err <= 1'b0;
            stat    <= SAOK;
        end else if (accept) begin
            cnt     <= 3'd0;
            wr_r    <= is_wr;
            addr_r  <= req_addr[ADDR_W-1:0];
            wdata_r <= req_wdata;
            valM    <= 64'd0;
            mem_err <= 1'b0;
            if (bad_ins) begin
                stat <= SINS;
            end else if (icode == HALT) begin
                stat <= SHLT;
            end else if ((is_wr || is_rd) && addr_bad) begin
                mem_err <= 1'b1;
                stat    <= SADR;
            end
        end else if (state == ST_XFER) begin
            cnt <= cnt + 3'd1;
            if (!wr_r) begin
                valM[byte_lsb +: 8] <= ram_rdata;
            end
        end
    end

    // Byte k of the quadword lives at addr+k (little-endian).
    assign byte_lsb  = {cnt, 3'b000};
    assign ram_addr  = addr_r + ADDR_W'(cnt);
    assign ram_we    = (state == ST_XFER) && wr_r;
    assign ram_wdata = wdata_r[byte_lsb +: 8];

    data_mem_byte #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_addr),
        .wdata(ram_wdata),
        .raddr(ram_addr),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: transaction-level reference model with a
// per-cycle compare process, plus directed literal checks.
module tb_mem_access;

    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, instruct_err;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        busy, done, mem_err;
    logic [63:0] valM;
    logic [1:0]  stat;

    mem_access #(.MEM_BYTES(MB), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .instruct_err(instruct_err), .valA(valA), .valE(valE), .valP(valP),
        .busy(busy), .done(done), .valM(valM), .mem_err(mem_err), .stat(stat)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: whole-transaction view of the memory stage.
    logic [7:0]  m_mem [MB];
    int          m_rem = 0;
    logic        m_wr = 1'b0;
    logic [63:0] m_addr = 64'd0, m_wd = 64'd0, m_valM = 64'd0;
    logic        m_err = 1'b0;
    logic [1:0]  m_stat = 2'd1;

    function automatic logic [63:0] rd64(input logic [63:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = m_mem[int'(a[9:0]) + k];
        return r;
    endfunction

    function automatic logic [63:0] ea(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e);
        return (ic == 4'h9 || ic == 4'hB) ? a : e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (m_rem >= 2 && m_wr)
                for (int k = 0; k < 9 - m_rem; k++) m_mem[int'(m_addr[9:0]) + k] <= m_wd[8*k +: 8];
            m_rem  <= 0;
            m_valM <= 64'd0;
            m_err  <= 1'b0;
            m_stat <= 2'd1;
        end else if (m_rem > 0) begin
            if (m_rem == 2 && m_wr)
                for (int k = 0; k < 8; k++) m_mem[int'(m_addr[9:0]) + k] <= m_wd[8*k +: 8];
            m_rem <= m_rem - 1;
        end else if (start && m_stat == 2'd1) begin
            m_valM <= 64'd0;
            m_err  <= 1'b0;
            m_wr   <= 1'b0;
            if (instruct_err || icode > 4'hB) begin
                m_stat <= 2'd0; m_rem <= 1;
            end else if (icode == 4'h0) begin
                m_stat <= 2'd2; m_rem <= 1;
            end else if (icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
                if (ea(icode, valA, valE) > 64'(MB - 8)) begin
                    m_err <= 1'b1; m_stat <= 2'd3; m_rem <= 1;
                end else begin
                    m_rem  <= 9;
                    m_addr <= ea(icode, valA, valE);
                    m_wr   <= (icode == 4'h4 || icode == 4'hA || icode == 4'h8);
                    m_wd   <= (icode == 4'h8) ? valP : valA;
                    if (icode == 4'h5 || icode == 4'h9 || icode == 4'hB)
                        m_valM <= rd64(ea(icode, valA, valE));
                end
            end else begin
                m_rem <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", 64'(busy), 64'(m_rem > 0));
            chk("done", 64'(done), 64'(m_rem == 1));
            chk("stat", 64'(stat), 64'(m_stat));
            chk("mem_err", 64'(mem_err), 64'(m_err));
            if (m_rem <= 1) chk("valM", valM, m_valM);
        end
    end

    // exp_lat > 0: required cycles to done; 0: just require done; < 0: start must be ignored.
    task automatic do_op(input logic [3:0] ic, input logic ie, input logic [63:0] a,
                         input logic [63:0] e, input logic [63:0] p, input int exp_lat, input bit poke);
        int n;
        @(negedge clk);
        icode = ic; instruct_err = ie; valA = a; valE = e; valP = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        icode = 4'($urandom); instruct_err = 1'($urandom);
        valA = {$urandom, $urandom}; valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
        n = 1;
        while (!done && n < 15) begin
            @(negedge clk);
            n++;
            start = (poke && n == 3);
        end
        start = 1'b0;
        if (exp_lat > 0)      chk("latency", 64'(n), 64'(exp_lat));
        else if (exp_lat < 0) chk("ignored_start", 64'(done), 64'd0);
        else                  chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_ram_image();
        int bad = 0;
        for (int i = 0; i < MB; i++) if (dut.u_ram.mem[i] !== m_mem[i]) bad++;
        chk("ram_image", 64'(bad), 64'd0);
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] ad, va, ve;
        int          extra;
        start = 1'b0; icode = 4'h0; instruct_err = 1'b0;
        valA = 64'd0; valE = 64'd0; valP = 64'd0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_mem_err", 64'(mem_err), 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < MB / 8; i++)
            do_op(4'h4, 1'b0, {$urandom, $urandom}, 64'(i * 8), 64'd0, 9, 1'b0);
        chk_ram_image();

        do_op(4'h4, 1'b0, 64'h1122334455667788, 64'h100, 64'd0, 9, 1'b0);
        chk("rm_ram100", 64'(dut.u_ram.mem[10'h100]), 64'h88);
        chk("rm_ram107", 64'(dut.u_ram.mem[10'h107]), 64'h11);
        chk("rm_stat", 64'(stat), 64'd1);
        do_op(4'h5, 1'b0, 64'd0, 64'h100, 64'd0, 9, 1'b0);
        chk("mr_valM", valM, 64'h1122334455667788);
        do_op(4'hB, 1'b0, 64'h100, 64'd0, 64'd0, 9, 1'b0);
        chk("pop_valM", valM, 64'h1122334455667788);

        for (int i = 0; i < 80; i++) begin
            ic = 4'($urandom_range(1, 11));
            if ($urandom_range(0, 7) == 0) ad = 64'(MB - 8 + $urandom_range(1, 300));
            else                           ad = 64'($urandom_range(0, MB - 8));
            if (ic == 4'h9 || ic == 4'hB) begin va = ad; ve = {$urandom, $urandom}; end
            else begin ve = ad; va = {$urandom, $urandom}; end
            do_op(ic, 1'b0, va, ve, {$urandom, $urandom}, 0, 1'b0);
            if (m_stat != 2'd1) do_reset();
        end
        chk_ram_image();

        do_op(4'h4, 1'b0, 64'hCAFEBABEDEADBEEF, 64'(MB - 8), 64'd0, 9, 1'b0);
        chk("edge_mem_err", 64'(mem_err), 64'd0);
        chk("edge_ram_last", 64'(dut.u_ram.mem[MB - 1]), 64'hCA);
        chk("edge_ram_first", 64'(dut.u_ram.mem[MB - 8]), 64'hEF);

        do_op(4'h5, 1'b0, 64'd0, 64'h100, 64'd0, 9, 1'b1);
        chk("poke_valM", valM, 64'h1122334455667788);
        extra = 0;
        repeat (12) begin @(negedge clk); if (done) extra++; end
        chk("poke_extra_done", 64'(extra), 64'd0);

        do_op(4'h4, 1'b0, 64'h5857565554535251, 64'h200, 64'd0, 9, 1'b0);
        @(negedge clk);
        icode = 4'h8; instruct_err = 1'b0; valP = 64'hAABBCCDDEEFF0011; valE = 64'h200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_valM", valM, 64'd0);
        chk("abort_mem_err", 64'(mem_err), 64'd0);
        chk("abort_stat", 64'(stat), 64'd1);
        chk("abort_ram200", 64'(dut.u_ram.mem[10'h200]), 64'h11);
        chk("abort_ram201", 64'(dut.u_ram.mem[10'h201]), 64'h00);
        chk("abort_ram202", 64'(dut.u_ram.mem[10'h202]), 64'hFF);
        chk("abort_ram203", 64'(dut.u_ram.mem[10'h203]), 64'h54);
        chk("abort_ram207", 64'(dut.u_ram.mem[10'h207]), 64'h58);
        @(negedge clk);
        rst = 1'b0;

        do_op(4'h4, 1'b0, 64'h1234, 64'(MB - 7), 64'd0, 1, 1'b0);
        chk("fault_mem_err", 64'(mem_err), 64'd1);
        chk("fault_stat", 64'(stat), 64'd3);
        chk_ram_image();
        do_op(4'h4, 1'b0, 64'h99, 64'h100, 64'd0, -1, 1'b0);
        chk("fault_sticky", 64'(stat), 64'd3);
        do_reset();
        do_op(4'h5, 1'b0, 64'd0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 1, 1'b0);
        chk("wrap_stat", 64'(stat), 64'd3);
        do_reset();

        do_op(4'h6, 1'b0, 64'd5, 64'h100, 64'd0, 1, 1'b0);
        chk("opq_valM", valM, 64'd0);
        chk("opq_stat", 64'(stat), 64'd1);
        do_op(4'h0, 1'b0, 64'd0, 64'd0, 64'd0, 1, 1'b0);
        chk("halt_stat", 64'(stat), 64'd2);
        do_op(4'h5, 1'b0, 64'd0, 64'h100, 64'd0, -1, 1'b0);
        chk("halt_sticky", 64'(stat), 64'd2);
        do_reset();
        do_op(4'h5, 1'b1, 64'd0, 64'h100, 64'd0, 1, 1'b0);
        chk("ins_stat", 64'(stat), 64'd0);
        do_reset();
        do_op(4'hC, 1'b0, 64'd0, 64'h100, 64'd0, 1, 1'b0);
        chk("bad_icode_stat", 64'(stat), 64'd0);
        do_reset();
        chk_ram_image();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
